// File: rtl/spi_ram_responder_if.sv
// Bus bundle between the CPU-side SPI master/test harness and spi_ram_responder.
// Carries the serial link, the backdoor preload port and the busy flag.
interface spi_ram_responder_if #(
   parameter int ADDR_BITS = 12
);
   logic                 spi_select;
   logic                 spi_clk_enable;
   logic                 spi_mosi;
   logic                 spi_miso;
   logic                 load_en;
   logic [ADDR_BITS-1:0] load_addr;
   logic [7:0]           load_data;
   logic                 busy;

   modport master (
      output spi_select, spi_clk_enable, spi_mosi, load_en, load_addr, load_data,
      input  spi_miso, busy
   );

   modport slave (
      input  spi_select, spi_clk_enable, spi_mosi, load_en, load_addr, load_data,
      output spi_miso, busy
   );
endinterface

// File: rtl/spi_ram_responder.sv
// SPI memory responder: decodes READ (0x03) / WRITE (0x02) + 24-bit address, serves a byte array.
// Optional: define SPI_RAM_FAST_READ_EN to accept 0x0B (read with 8 dummy bit edges).
module spi_ram_responder #(
   parameter int ADDR_BITS = 12
) (
   input  logic               clk,
   input  logic               rstn,
   spi_ram_responder_if.slave bus
);
   localparam int DEPTH = 1 << ADDR_BITS;

   typedef enum logic [2:0] {
      S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_READ, S_WRITE, S_IGNORE
   } state_t;

   logic [7:0]           r_mem [0:DEPTH-1];
   state_t               r_state;
   logic [4:0]           r_bit_cnt;
   logic [6:0]           r_cmd;
   logic                 r_is_read;
   logic [ADDR_BITS-1:0] r_addr;
   logic [7:0]           r_shift;
   logic                 r_miso;
   logic                 r_busy;
`ifdef SPI_RAM_FAST_READ_EN
   logic                 r_fast;
`endif

   logic                 w_wr_en;
   logic [7:0]           w_cmd;
   logic [7:0]           w_rd_byte;
   logic [7:0]           w_wr_byte;
   logic [ADDR_BITS-1:0] w_addr_in;
   logic [ADDR_BITS-1:0] w_addr_inc;
   logic [ADDR_BITS-1:0] w_rd_addr;

   assign w_cmd      = {r_cmd, bus.spi_mosi};
   assign w_addr_in  = {r_addr[ADDR_BITS-2:0], bus.spi_mosi};
   assign w_addr_inc = r_addr + 1'b1;
   assign w_wr_byte  = {bus.spi_mosi, r_shift[7:1]};
   assign w_wr_en    = !bus.spi_select && bus.spi_clk_enable &&
                       (r_state == S_WRITE) && (r_bit_cnt == 5'd7);

   // Unregistered read so the first data bit is on spi_miso right after the last address edge.
   always_comb begin
      w_rd_addr = r_addr;
      case (r_state)
         S_ADDR:  w_rd_addr = w_addr_in;
         S_READ:  w_rd_addr = w_addr_inc;
         default: w_rd_addr = r_addr;
      endcase
   end
   assign w_rd_byte = r_mem[w_rd_addr];

   // Backdoor is written last so it wins a same-address collision.
   always_ff @(posedge clk) begin
      if (w_wr_en) r_mem[r_addr] <= w_wr_byte;
      if (bus.load_en) r_mem[bus.load_addr] <= bus.load_data;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state   <= S_IDLE;
         r_bit_cnt <= '0;
         r_cmd     <= '0;
         r_is_read <= 1'b0;
         r_addr    <= '0;
         r_shift   <= '0;
         r_miso    <= 1'b0;
         r_busy    <= 1'b0;
`ifdef SPI_RAM_FAST_READ_EN
         r_fast    <= 1'b0;
`endif
      end else if (bus.spi_select) begin
         r_state   <= S_IDLE;
         r_bit_cnt <= '0;
         r_miso    <= 1'b0;
         r_busy    <= 1'b0;
      end else if (bus.spi_clk_enable) begin
         case (r_state)
            S_IDLE: begin
               r_cmd     <= {6'd0, bus.spi_mosi};
               r_bit_cnt <= 5'd1;
               r_busy    <= 1'b1;
               r_state   <= S_CMD;
            end
            S_CMD: begin
               r_cmd     <= w_cmd[6:0];
               r_bit_cnt <= r_bit_cnt + 5'd1;
               if (r_bit_cnt == 5'd7) begin
                  r_bit_cnt <= '0;
`ifdef SPI_RAM_FAST_READ_EN
                  r_fast    <= (w_cmd == 8'h0B);
`endif
                  case (w_cmd)
                     8'h03: begin r_state <= S_ADDR; r_is_read <= 1'b1; end
                     8'h02: begin r_state <= S_ADDR; r_is_read <= 1'b0; end
`ifdef SPI_RAM_FAST_READ_EN
                     8'h0B: begin r_state <= S_ADDR; r_is_read <= 1'b1; end
`endif
                     default: r_state <= S_IGNORE;
                  endcase
               end
            end
            S_ADDR: begin
               r_addr    <= w_addr_in;
               r_bit_cnt <= r_bit_cnt + 5'd1;
               if (r_bit_cnt == 5'd23) begin
                  r_bit_cnt <= '0;
                  if (!r_is_read) begin
                     r_state <= S_WRITE;
`ifdef SPI_RAM_FAST_READ_EN
                  end else if (r_fast) begin
                     r_state <= S_DUMMY;
`endif
                  end else begin
                     r_shift <= w_rd_byte;
                     r_miso  <= w_rd_byte[0];
                     r_state <= S_READ;
                  end
               end
            end
            S_DUMMY: begin
               r_miso    <= 1'b0;
               r_bit_cnt <= r_bit_cnt + 5'd1;
               if (r_bit_cnt == 5'd7) begin
                  r_bit_cnt <= '0;
                  r_shift   <= w_rd_byte;
                  r_miso    <= w_rd_byte[0];
                  r_state   <= S_READ;
               end
            end
            S_READ: begin
               if (r_bit_cnt == 5'd7) begin
                  r_bit_cnt <= '0;
                  r_addr    <= w_addr_inc;
                  r_shift   <= w_rd_byte;
                  r_miso    <= w_rd_byte[0];
               end else begin
                  r_bit_cnt <= r_bit_cnt + 5'd1;
                  r_shift   <= {1'b0, r_shift[7:1]};
                  r_miso    <= r_shift[1];
               end
            end
            S_WRITE: begin
               r_shift   <= w_wr_byte;
               r_bit_cnt <= r_bit_cnt + 5'd1;
               if (r_bit_cnt == 5'd7) begin
                  r_bit_cnt <= '0;
                  r_addr    <= w_addr_inc;
               end
            end
            default: r_miso <= 1'b0;
         endcase
      end
   end

   assign bus.spi_miso = r_miso;
   assign bus.busy     = r_busy;
endmodule

// File: tb/tb_spi_ram_responder.sv
// Self-checking bench for spi_ram_responder: vector table, hand-written corner sequences,
// and randomized write/read traffic checked against a flat byte-array memory model.
module tb_spi_ram_responder;
   localparam int AB    = 12;
   localparam int DEPTH = 1 << AB;

   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   spi_ram_responder_if #(.ADDR_BITS(AB)) bus ();
   spi_ram_responder #(.ADDR_BITS(AB)) dut (.clk(clk), .rstn(rstn), .bus(bus));

   int errors = 0;
   int checks = 0;
   logic [7:0] model_mem [DEPTH];

   typedef struct {
      string       name;
      logic [7:0]  cmd;
      logic [23:0] addr;
      logic [31:0] exp_word;
      logic        exp_busy;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end else begin
         $display("ok   %s: %h", name, act);
      end
   endtask

   // One bit edge; returns the spi_miso value the core would sample on this edge.
   task automatic spi_bit(input logic b, output logic s);
      @(negedge clk);
      bus.spi_select     = 1'b0;
      bus.spi_clk_enable = 1'b1;
      bus.spi_mosi       = b;
      bus.load_en        = 1'b0;
      s = bus.spi_miso;
      @(posedge clk);
   endtask

   task automatic spi_bit_ld(input logic b, input logic [AB-1:0] la, input logic [7:0] ld);
      @(negedge clk);
      bus.spi_select     = 1'b0;
      bus.spi_clk_enable = 1'b1;
      bus.spi_mosi       = b;
      bus.load_en        = 1'b1;
      bus.load_addr      = la;
      bus.load_data      = ld;
      @(posedge clk);
   endtask

   task automatic deselect();
      @(negedge clk);
      bus.spi_select     = 1'b1;
      bus.spi_clk_enable = 1'b0;
      bus.load_en        = 1'b0;
      @(posedge clk);
   endtask

   task automatic bd_write(input logic [AB-1:0] a, input logic [7:0] d);
      @(negedge clk);
      bus.load_en   = 1'b1;
      bus.load_addr = a;
      bus.load_data = d;
      @(posedge clk);
      @(negedge clk);
      bus.load_en = 1'b0;
      model_mem[a] = d;
   endtask

   task automatic send_msb(input logic [31:0] v, input int nbits);
      logic s;
      for (int i = nbits - 1; i >= 0; i--) spi_bit(v[i], s);
   endtask

   task automatic read_bytes(input int n, output logic [7:0] got [8]);
      logic s;
      for (int k = 0; k < 8; k++) got[k] = 8'h00;
      for (int k = 0; k < n; k++)
         for (int b = 0; b < 8; b++) begin
            spi_bit(1'($urandom_range(0, 1)), s);
            got[k][b] = s;
         end
   endtask

   task automatic spi_read(input logic [7:0] cmd, input logic [23:0] addr, input int n,
                           output logic [7:0] got [8], output logic bsy);
      send_msb({24'd0, cmd}, 8);
      send_msb({8'd0, addr}, 24);
`ifdef SPI_RAM_FAST_READ_EN
      if (cmd == 8'h0B) send_msb(32'd0, 8);
`endif
      read_bytes(n, got);
      @(negedge clk);
      bsy = bus.busy;
      deselect();
   endtask

   task automatic spi_write(input logic [23:0] addr, input int n, input logic [7:0] wd [8]);
      logic s;
      send_msb(32'h02, 8);
      send_msb({8'd0, addr}, 24);
      for (int k = 0; k < n; k++) begin
         for (int b = 0; b < 8; b++) spi_bit(wd[k][b], s);
         model_mem[(int'(addr) + k) % DEPTH] = wd[k];
      end
      deselect();
   endtask

   function automatic logic [31:0] pack4(input logic [7:0] g [8]);
      return {g[3], g[2], g[1], g[0]};
   endfunction

   vec_t       vecs [5];
   logic [7:0] got [8];
   logic [7:0] wd [8];
   logic       bsy;
   logic       s;
   logic       hold;
   logic [7:0] old_b;
   logic [23:0] ra;
   int         n;

   initial begin
      #600000;
      errors++;
      $display("FAIL watchdog: got timeout, expected completion");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      vecs[0] = '{"read_0x100",     8'h03, 24'h000100, 32'h00000513, 1'b1};
      vecs[1] = '{"read_wrap",      8'h03, 24'h000FFE, 32'hD4C3B2A1, 1'b1};
      vecs[2] = '{"read_hi_ignore", 8'h03, 24'hABC100, 32'h00000513, 1'b1};
      vecs[3] = '{"unknown_9F",     8'h9F, 24'h000100, 32'h00000000, 1'b1};
`ifdef SPI_RAM_FAST_READ_EN
      vecs[4] = '{"fast_read_0B",   8'h0B, 24'h000100, 32'h00000513, 1'b1};
`else
      vecs[4] = '{"no_fast_0B",     8'h0B, 24'h000100, 32'h00000000, 1'b1};
`endif

      bus.spi_select = 1'b1; bus.spi_clk_enable = 1'b0; bus.spi_mosi = 1'b0;
      bus.load_en = 1'b0; bus.load_addr = '0; bus.load_data = '0;
      rstn = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_miso", {31'd0, bus.spi_miso}, 32'd0);
      check("reset_busy", {31'd0, bus.busy}, 32'd0);
      rstn = 1'b1;

      for (int i = 0; i < DEPTH; i++) bd_write(AB'(i), 8'($urandom));
      bd_write(12'h100, 8'h13); bd_write(12'h101, 8'h05);
      bd_write(12'h102, 8'h00); bd_write(12'h103, 8'h00);
      bd_write(12'hFFE, 8'hA1); bd_write(12'hFFF, 8'hB2);
      bd_write(12'h000, 8'hC3); bd_write(12'h001, 8'hD4);

      // Reset mid-read: outputs must clear without waiting for a clock edge.
      send_msb(32'h03, 8);
      send_msb(32'h000100, 24);
      for (int b = 0; b < 10; b++) spi_bit(1'b0, s);
      @(negedge clk);
      rstn = 1'b0;
      #1;
      check("rst_mid_miso", {31'd0, bus.spi_miso}, 32'd0);
      check("rst_mid_busy", {31'd0, bus.busy}, 32'd0);
      bus.spi_select = 1'b1; bus.spi_clk_enable = 1'b0;
      @(negedge clk);
      rstn = 1'b1;

      for (int i = 0; i < 5; i++) begin
         spi_read(vecs[i].cmd, vecs[i].addr, 4, got, bsy);
         check(vecs[i].name, pack4(got), vecs[i].exp_word);
         check({vecs[i].name, "_busy"}, {31'd0, bsy}, {31'd0, vecs[i].exp_busy});
      end

      wd[0] = 8'hEF; wd[1] = 8'hBE; wd[2] = 8'hAD; wd[3] = 8'hDE;
      spi_write(24'h000020, 4, wd);
      check("bd_bytes_20", {dut.r_mem[35], dut.r_mem[34], dut.r_mem[33], dut.r_mem[32]},
            32'hDEADBEEF);
      spi_read(8'h03, 24'h000020, 4, got, bsy);
      check("readback_20", pack4(got), 32'hDEADBEEF);

      // Stall mid-byte: 4 bits in, miso sits on bit4 of 0x13 (=1) for the whole stall.
      send_msb(32'h03, 8);
      send_msb(32'h000100, 24);
      for (int k = 0; k < 8; k++) got[k] = 8'h00;
      for (int b = 0; b < 4; b++) begin spi_bit(1'b0, s); got[0][b] = s; end
      hold = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         bus.spi_clk_enable = 1'b0;
         if (bus.spi_miso !== 1'b1) hold = 1'b0;
         @(posedge clk);
      end
      check("stall_hold", {31'd0, hold}, 32'd1);
      for (int b = 4; b < 32; b++) begin spi_bit(1'b0, s); got[b / 8][b % 8] = s; end
      deselect();
      check("stall_word", pack4(got), 32'h00000513);

      bd_write(12'h200, 8'h5A);
      send_msb(32'h02, 8);
      send_msb(32'h000200, 24);
      send_msb(32'h5, 4);
      deselect();
      spi_read(8'h03, 24'h000200, 1, got, bsy);
      check("partial_write", {24'd0, got[0]}, 32'h0000005A);

      // SPI byte write and backdoor land on 0x300 in the same cycle.
      send_msb(32'h02, 8);
      send_msb(32'h000300, 24);
      for (int b = 0; b < 7; b++) spi_bit(1'b1, s);
      spi_bit_ld(1'b1, 12'h300, 8'hCC);
      deselect();
      model_mem[12'h300] = 8'hCC;
      spi_read(8'h03, 24'h000300, 1, got, bsy);
      check("collision", {24'd0, got[0]}, 32'h000000CC);

      // Backdoor write to the byte being fetched on the last address edge: old value served.
      old_b = model_mem[12'h310];
      send_msb(32'h03, 8);
      send_msb(32'h000310 >> 1, 23);
      spi_bit_ld(1'b0, 12'h310, ~old_b);
      read_bytes(1, got);
      deselect();
      check("read_old", {24'd0, got[0]}, {24'd0, old_b});
      model_mem[12'h310] = ~old_b;
      spi_read(8'h03, 24'h000310, 1, got, bsy);
      check("read_new", {24'd0, got[0]}, {24'd0, ~old_b});

      for (int it = 0; it < 24; it++) begin
         n  = $urandom_range(1, 4);
         ra = 24'($urandom);
         for (int k = 0; k < 8; k++) wd[k] = 8'($urandom);
         if (it % 2 == 0) spi_write(ra, n, wd);
         else for (int k = 0; k < n; k++) bd_write(AB'((int'(ra) + k) % DEPTH), wd[k]);
         spi_read(8'h03, ra, n, got, bsy);
         for (int k = 0; k < n; k++)
            check($sformatf("rand%0d_b%0d", it, k), {24'd0, got[k]},
                  {24'd0, model_mem[(int'(ra) + k) % DEPTH]});
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
